// File: rtl/mem_copy_engine.sv
// mem_copy_engine: single-channel memory copy / fill engine.
//
// Copies len words from a source memory (fixed read latency SRC_LAT) to a
// destination memory, or fills the destination with a constant word.
// Source and destination addresses wrap modulo 2^ADDR_W.
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   start, mode       request a transfer (sampled in IDLE); 0 = copy, 1 = fill
//   src_base,dst_base first source / destination address
//   len               word count, 0 .. 2^ADDR_W
//   fill_value        data written in fill mode
//   abort             terminate the active transfer
//   src_re/src_addr   source read port; src_data returns SRC_LAT cycles later
//   dst_we/dst_addr/dst_data  destination write port
//   busy, done, aborted, words_written  status
module mem_copy_engine #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int SRC_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              abort,
    output logic              src_re,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic              dst_we,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] dst_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W:0]   words_written
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]         state_q, state_d;
    logic               mode_q;
    logic [ADDR_W-1:0]  src_base_q, dst_base_q;
    logic [ADDR_W:0]    len_q, last_idx;
    logic [ADDR_W:0]    rd_cnt_q, wr_cnt_q, wr_cnt_d;
    logic [DATA_W-1:0]  fill_q;
    logic               aborted_q;
    // Bit i set: a read issued i+1 cycles ago is still in flight.
    logic [SRC_LAT-1:0] vld_q, vld_d;
    logic               active, rd_en, wr_en;

    assign active   = (state_q == ISSUE) || (state_q == DRAIN);
    assign rd_en    = (state_q == ISSUE) && !mode_q;
    assign wr_en    = mode_q ? (state_q == ISSUE) : (active && vld_q[SRC_LAT-1]);
    assign last_idx = len_q - ONE;
    assign wr_cnt_d = wr_en ? (wr_cnt_q + ONE) : wr_cnt_q;
    assign vld_d    = (vld_q << 1) | SRC_LAT'(rd_en);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = (len == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (abort) begin
                    state_d = DONE;
                end else if (mode_q ? (wr_cnt_q == last_idx) : (rd_cnt_q == last_idx)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Compare against the post-write count so done follows the last write directly.
                if (abort || (wr_cnt_d == len_q)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            src_base_q <= '0;
            dst_base_q <= '0;
            len_q      <= '0;
            fill_q     <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            aborted_q  <= 1'b0;
            vld_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q     <= mode;
                        src_base_q <= src_base;
                        dst_base_q <= dst_base;
                        len_q      <= len;
                        fill_q     <= fill_value;
                        rd_cnt_q   <= '0;
                        wr_cnt_q   <= '0;
                        aborted_q  <= 1'b0;
                        vld_q      <= '0;
                    end
                end
                ISSUE, DRAIN: begin
                    // A write in the abort cycle still lands, so it is counted.
                    wr_cnt_q <= wr_cnt_d;
                    if (abort) begin
                        aborted_q <= 1'b1;
                        vld_q     <= '0;
                    end else begin
                        vld_q <= vld_d;
                        if (rd_en) rd_cnt_q <= rd_cnt_q + ONE;
                    end
                end
                default: vld_q <= '0;
            endcase
        end
    end

    // Address and data buses are held at zero whenever their strobe is low.
    assign src_re        = rd_en;
    assign src_addr      = rd_en ? (src_base_q + rd_cnt_q[ADDR_W-1:0]) : '0;
    assign dst_we        = wr_en;
    assign dst_addr      = wr_en ? (dst_base_q + wr_cnt_q[ADDR_W-1:0]) : '0;
    assign dst_data      = !wr_en ? '0 : (mode_q ? fill_q : src_data);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign aborted       = aborted_q;
    assign words_written = wr_cnt_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Testbench for mem_copy_engine: two instances (SRC_LAT = 1 and 3) share all
// inputs; a transaction-level model fills per-instance expectation queues and a
// negedge monitor compares every read, write and done pulse as it appears.
module tb_mem_copy_engine;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] fill_value = '0;

    logic          s_re   [2];
    logic [AW-1:0] s_addr [2];
    logic [DW-1:0] s_data [2];
    logic          d_we   [2];
    logic [AW-1:0] d_addr [2];
    logic [DW-1:0] d_data [2];
    logic          bsy    [2];
    logic          dn     [2];
    logic          abd    [2];
    logic [AW:0]   ww     [2];

    logic [DW-1:0] mem [256];
    logic [AW-1:0] rp0;
    logic [AW-1:0] rp1 [3];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;
    typedef struct packed {
        logic [31:0] cyc;
        logic        ab;
        logic [AW:0] ww;
    } dn_t;

    ev_t rq [2][$];
    ev_t wq [2][$];
    dn_t dq [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Source memories with 1- and 3-cycle read latency.
    always @(posedge clk) begin
        rp0    <= s_addr[0];
        rp1[0] <= s_addr[1];
        rp1[1] <= rp1[0];
        rp1[2] <= rp1[1];
    end
    assign s_data[0] = mem[rp0];
    assign s_data[1] = mem[rp1[2]];

    mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW), .SRC_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_base(src_base), .dst_base(dst_base), .len(len), .fill_value(fill_value),
        .abort(abort), .src_re(s_re[0]), .src_addr(s_addr[0]), .src_data(s_data[0]),
        .dst_we(d_we[0]), .dst_addr(d_addr[0]), .dst_data(d_data[0]),
        .busy(bsy[0]), .done(dn[0]), .aborted(abd[0]), .words_written(ww[0])
    );

    mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW), .SRC_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_base(src_base), .dst_base(dst_base), .len(len), .fill_value(fill_value),
        .abort(abort), .src_re(s_re[1]), .src_addr(s_addr[1]), .src_data(s_data[1]),
        .dst_we(d_we[1]), .dst_addr(d_addr[1]), .dst_data(d_data[1]),
        .busy(bsy[1]), .done(dn[1]), .aborted(abd[1]), .words_written(ww[1])
    );

    function automatic void chk(string nm, int i, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d cycle=%0d got=0x%0h expected=0x%0h", nm, i, cyc, act, exp);
        end
    endfunction

    task automatic chk_zero();
        for (int i = 0; i < 2; i++) begin
            chk("zero_src_re", i, 64'(s_re[i]), 64'd0);
            chk("zero_src_addr", i, 64'(s_addr[i]), 64'd0);
            chk("zero_dst_we", i, 64'(d_we[i]), 64'd0);
            chk("zero_dst_addr", i, 64'(d_addr[i]), 64'd0);
            chk("zero_dst_data", i, 64'(d_data[i]), 64'd0);
            chk("zero_busy", i, 64'(bsy[i]), 64'd0);
            chk("zero_done", i, 64'(dn[i]), 64'd0);
            chk("zero_aborted", i, 64'(abd[i]), 64'd0);
            chk("zero_words", i, 64'(ww[i]), 64'd0);
        end
    endtask

    // Transfer-level model: read k in cycle k+1, copy write k in cycle k+1+lat,
    // fill write k in cycle k+1; an abort in cycle a (1 <= a < done cycle) keeps
    // events up to a and pulses done in a+1; a reset in cycle r drops events after r.
    task automatic model(input int i, input int lat, input logic md, input logic [AW-1:0] sb,
                         input logic [AW-1:0] db, input int n, input logic [DW-1:0] fv,
                         input int t0, input int ab_at, input int rs_at,
                         output logic exp_ab, output int exp_ww);
        int  d, stop, cnt, wc;
        bit  aborts;
        ev_t e;
        dn_t de;
        d      = (n == 0) ? 1 : (md ? n + 2 : n + lat + 1);
        aborts = (ab_at >= 1) && (ab_at < d);
        stop   = aborts ? ab_at : ((rs_at >= 0) ? rs_at : 32'h4000_0000);
        cnt    = 0;
        for (int k = 0; k < n; k++) begin
            if (!md) begin
                if (k + 1 <= stop) begin
                    e.cyc = 32'(t0 + k + 1); e.addr = sb + AW'(k); e.data = '0;
                    rq[i].push_back(e);
                end
                wc = k + 1 + lat;
                e.data = mem[sb + AW'(k)];
            end else begin
                wc = k + 1;
                e.data = fv;
            end
            if (wc <= stop) begin
                e.cyc = 32'(t0 + wc); e.addr = db + AW'(k);
                wq[i].push_back(e);
                cnt++;
            end
        end
        exp_ab = 1'b0;
        exp_ww = n;
        if (aborts) begin
            de.cyc = 32'(t0 + stop + 1); de.ab = 1'b1; de.ww = (AW+1)'(cnt);
            dq[i].push_back(de);
            exp_ab = 1'b1;
            exp_ww = cnt;
        end else if (rs_at < 0 || d <= rs_at) begin
            de.cyc = 32'(t0 + d); de.ab = 1'b0; de.ww = (AW+1)'(n);
            dq[i].push_back(de);
        end
        if (rs_at >= 0) begin
            exp_ab = 1'b0;
            exp_ww = 0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                bit exp_r, exp_w, exp_d;
                while (rq[i].size() > 0 && int'(rq[i][0].cyc) < cyc) begin
                    chk("src_re_missing", i, 64'(cyc), 64'(rq[i][0].cyc));
                    void'(rq[i].pop_front());
                end
                while (wq[i].size() > 0 && int'(wq[i][0].cyc) < cyc) begin
                    chk("dst_we_missing", i, 64'(cyc), 64'(wq[i][0].cyc));
                    void'(wq[i].pop_front());
                end
                while (dq[i].size() > 0 && int'(dq[i][0].cyc) < cyc) begin
                    chk("done_missing", i, 64'(cyc), 64'(dq[i][0].cyc));
                    void'(dq[i].pop_front());
                end
                exp_r = (rq[i].size() > 0) && (int'(rq[i][0].cyc) == cyc);
                exp_w = (wq[i].size() > 0) && (int'(wq[i][0].cyc) == cyc);
                exp_d = (dq[i].size() > 0) && (int'(dq[i][0].cyc) == cyc);
                if (s_re[i] || exp_r) begin
                    chk("src_re", i, 64'(s_re[i]), 64'(exp_r));
                    if (exp_r) begin
                        if (s_re[i]) chk("src_addr", i, 64'(s_addr[i]), 64'(rq[i][0].addr));
                        void'(rq[i].pop_front());
                    end
                end
                if (d_we[i] || exp_w) begin
                    chk("dst_we", i, 64'(d_we[i]), 64'(exp_w));
                    if (exp_w) begin
                        if (d_we[i]) begin
                            chk("dst_addr", i, 64'(d_addr[i]), 64'(wq[i][0].addr));
                            chk("dst_data", i, 64'(d_data[i]), 64'(wq[i][0].data));
                        end
                        void'(wq[i].pop_front());
                    end
                end
                if (dn[i] || exp_d) begin
                    chk("done", i, 64'(dn[i]), 64'(exp_d));
                    if (exp_d) begin
                        if (dn[i]) begin
                            chk("done_aborted", i, 64'(abd[i]), 64'(dq[i][0].ab));
                            chk("done_words", i, 64'(ww[i]), 64'(dq[i][0].ww));
                        end
                        void'(dq[i].pop_front());
                    end
                end
            end
        end
    end

    // One transfer: start in cycle t0 (relative 0); a stray start and scrambled
    // inputs in cycle 1 must be ignored; optional abort/reset at relative cycles.
    task automatic run(input logic md, input logic [AW-1:0] sb, input logic [AW-1:0] db,
                       input int n, input logic [DW-1:0] fv, input int ab_at, input int rs_at);
        int   t0;
        logic ea0, ea1;
        int   ew0, ew1;
        @(negedge clk);
        mode = md; src_base = sb; dst_base = db; len = (AW+1)'(n); fill_value = fv;
        start = 1'b1;
        abort = (ab_at == 0);
        t0 = cyc;
        model(0, 1, md, sb, db, n, fv, t0, ab_at, rs_at, ea0, ew0);
        model(1, 3, md, sb, db, n, fv, t0, ab_at, rs_at, ea1, ew1);
        for (int k = 1; k <= n + 8; k++) begin
            @(negedge clk);
            if (rs_at >= 0 && k == rs_at + 1) begin
                reset = 1'b0;
                chk_zero();
            end
            start = (k == 1);
            if (k == 1) begin
                mode = 1'($urandom); src_base = AW'($urandom); dst_base = AW'($urandom);
                len = (AW+1)'($urandom); fill_value = $urandom;
            end
            abort = (k == ab_at);
            if (k == rs_at) reset = 1'b1;
        end
        start = 1'b0;
        abort = 1'b0;
        chk("hold_words", 0, 64'(ww[0]), 64'(ew0));
        chk("hold_words", 1, 64'(ww[1]), 64'(ew1));
        chk("hold_aborted", 0, 64'(abd[0]), 64'(ea0));
        chk("hold_aborted", 1, 64'(abd[1]), 64'(ea1));
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = DW'(a);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero();
        reset = 1'b0;
        mon_en = 1'b1;

        run(1'b0, 8'h10, 8'h80, 4, 32'h0, -1, -1);          // basic copy
        run(1'b1, 8'h00, 8'hFE, 4, 32'hDEADBEEF, -1, -1);   // fill with wrap
        run(1'b0, 8'h33, 8'h44, 0, 32'h0, -1, -1);          // empty copy
        run(1'b1, 8'h33, 8'h44, 0, 32'h1234, -1, -1);       // empty fill
        run(1'b0, 8'h05, 8'hF0, 256, 32'h0, -1, -1);        // full-range copy
        run(1'b0, 8'h20, 8'h60, 10, 32'h0, 4, -1);          // abort mid copy
        run(1'b0, 8'h00, 8'h40, 8, 32'h0, -1, 3);           // reset mid copy
        run(1'b0, 8'h08, 8'h18, 5, 32'h0, -1, -1);          // normal after reset
        run(1'b0, 8'hFD, 8'h02, 6, 32'h0, 0, -1);           // abort with start ignored
        run(1'b1, 8'h00, 8'h10, 6, 32'hA5A5_0F0F, 3, -1);   // abort mid fill

        for (int t = 0; t < 25; t++) begin
            logic       md;
            int         n, ab_at, rs_at;
            for (int a = 0; a < 256; a++) mem[a] = $urandom;
            md    = 1'($urandom_range(0, 1));
            n     = ($urandom_range(0, 9) == 0) ? 256 : int'($urandom_range(0, 24));
            ab_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n + 5)) : -1;
            rs_at = (ab_at < 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, n + 3)) : -1;
            run(md, AW'($urandom), AW'($urandom), n, $urandom, ab_at, rs_at);
        end

        repeat (4) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reads_left", i, 64'(rq[i].size()), 64'd0);
            chk("writes_left", i, 64'(wq[i].size()), 64'd0);
            chk("dones_left", i, 64'(dq[i].size()), 64'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, memory address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-003 The block SHALL have parameter SRC_LAT, default 1, source read latency in cycles, legal range 1..3.
REQ-004 Port clk SHALL be an input of width 1: clock; all logic on its rising edge.
REQ-005 Port reset SHALL be an input of width 1: reset, synchronous, active-high.
REQ-006 Port start SHALL be an input of width 1: request a transfer, sampled only in IDLE.
REQ-007 Port mode SHALL be an input of width 1: 0 = copy src->dst, 1 = fill dst with fill_value.
REQ-008 Port src_base SHALL be an input of width ADDR_W: first source address.
REQ-009 Port dst_base SHALL be an input of width ADDR_W: first destination address.
REQ-010 Port len SHALL be an input of width ADDR_W+1: word count, 0..2^ADDR_W.
REQ-011 Port fill_value SHALL be an input of width DATA_W: fill-mode data.
REQ-012 Port abort SHALL be an input of width 1: terminate the active transfer.
REQ-013 Port src_re SHALL be an output of width 1: source read enable.
REQ-014 Port src_addr SHALL be an output of width ADDR_W: source read address.
REQ-015 Port src_data SHALL be an input of width DATA_W: source read data, valid SRC_LAT cycles after the src_re cycle.
REQ-016 Port dst_we SHALL be an output of width 1: destination write enable.
REQ-017 Port dst_addr SHALL be an output of width ADDR_W: destination write address.
REQ-018 Port dst_data SHALL be an output of width DATA_W: destination write data.
REQ-019 Port busy SHALL be an output of width 1: high in every state except IDLE.
REQ-020 Port done SHALL be an output of width 1: one-cycle pulse at transfer end.
REQ-021 Port aborted SHALL be an output of width 1: valid with done; 1 = transfer ended by abort.
REQ-022 Port words_written SHALL be an output of width ADDR_W+1: dst writes performed in the current/last transfer.

Function
REQ-023 The FSM SHALL have states IDLE, ISSUE, DRAIN, DONE; unused encodings SHALL go to IDLE.
REQ-024 In IDLE with start=1, the block SHALL latch mode, src_base, dst_base, len and fill_value, clear words_written and counters, and go to ISSUE; if len=0 it SHALL go to DONE.
REQ-025 In ISSUE in copy mode, the block SHALL assert src_re for exactly len consecutive cycles, with src_addr = (src_base + rd_cnt) mod 2^ADDR_W.
REQ-026 Read data SHALL be tracked by a SRC_LAT-deep valid/address pipeline; dst_we SHALL assert in the cycle src_data is valid, with dst_data = src_data.
REQ-027 dst_addr SHALL be (dst_base + wr_cnt) mod 2^ADDR_W; both addresses SHALL wrap past 2^ADDR_W-1 to 0.
REQ-028 In fill mode, src_re SHALL stay 0 and dst_we SHALL assert for len consecutive cycles from the first ISSUE cycle, with dst_data = latched fill_value.
REQ-029 After the last read (copy) or last write (fill), the FSM SHALL go to DRAIN, then to DONE once words_written = len.
REQ-030 Timing with start sampled in cycle 0: copy SHALL write in cycles 1+SRC_LAT .. len+SRC_LAT and pulse done in cycle len+SRC_LAT+1; fill SHALL write in cycles 1..len and pulse done in cycle len+2.
REQ-031 DONE SHALL last one cycle with done=1, then return to IDLE; aborted and words_written SHALL hold until the next accepted start.
REQ-032 start outside IDLE SHALL be ignored; start and abort together in IDLE SHALL start the transfer, and that abort SHALL be ignored.
REQ-033 abort sampled high in ISSUE or DRAIN SHALL force src_re=0 and dst_we=0 from the next cycle, discard in-flight reads, go to DONE, and set aborted=1; abort in IDLE or DONE SHALL be ignored.
REQ-034 Input changes during a transfer SHALL NOT affect it.

Reset
REQ-035 reset SHALL, at any time including mid-transfer, force IDLE and clear src_re, dst_we, busy, done, aborted, words_written, the counters and the pipeline valid bits; pending writes SHALL be dropped.
REQ-036 All outputs SHALL read 0 in the cycle after reset is sampled high.

Verification
REQ-037 Copy, SRC_LAT=1, src_base=0x10, dst_base=0x80, len=4 -> dst writes to 0x80..0x83 with src words 0x10..0x13 in cycles 2-5, done in cycle 6, aborted=0, words_written=4.
REQ-038 Fill, dst_base=0xFE, len=4, fill_value=0xDEADBEEF -> writes to 0xFE, 0xFF, 0x00, 0x01, done in cycle 6.
REQ-039 len=0, either mode -> no src_re and no dst_we, done pulses one cycle after start, words_written=0.
REQ-040 Copy len=256 with ADDR_W=8 and SRC_LAT=3 -> 256 writes, done in cycle 260, start during busy is ignored.
REQ-041 Copy len=10 with abort in cycle 4 -> no src_re/dst_we from cycle 5, done with aborted=1, words_written=3 (writes in cycles 2-4).
REQ-042 reset in cycle 3 of a len=8 copy -> all outputs 0 from the next cycle, busy=0, and a following start runs normally.
